// File: rtl/haze_pkg.sv
// Shared constants and helpers for the add_haze haze-synthesis pipeline.
// Depth fog is built only when ADD_HAZE_DEPTH_FOG_EN is defined.
package haze_pkg;
  localparam int PIX_W      = 8;
  localparam int LATENCY    = 3;
  localparam int T_MIN      = 16;
  localparam int LINE_SHIFT = 2;
  localparam int LINE_CNT_W = 10;
  localparam int PROD_W     = 17;
  localparam int SUM_W      = 18;
  localparam int ROUND      = 128;
  localparam int PIX_MAX    = 255;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  // The blend cannot exceed 255, but saturate anyway so a bad operand never wraps.
  function automatic logic [PIX_W-1:0] clamp_pix(input logic [SUM_W-PIX_W-1:0] v);
    return (v > (SUM_W-PIX_W)'(PIX_MAX)) ? PIX_W'(PIX_MAX) : v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/haze_blend_ch.sv
// One colour channel of the haze blend: S1 products, S2 rounded sum, S3 shift/clamp.
module haze_blend_ch
  import haze_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] j,
  input  logic [PIX_W-1:0] t_eff,
  input  logic [PIX_W-1:0] a_lvl,
  input  logic             en,
  output logic [PIX_W-1:0] pix
);
  logic [PIX_W:0]    inv_t;
  logic [PROD_W-1:0] prod_j;
  logic [PROD_W-1:0] prod_a;
  logic [SUM_W-1:0]  sum;

  assign inv_t = (PIX_W+1)'(1 << PIX_W) - {1'b0, t_eff};

  // en is the data-enable as it enters S3, so blanked pixels leave as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_j <= '0;
      prod_a <= '0;
      sum    <= '0;
      pix    <= '0;
    end else begin
      prod_j <= PROD_W'(j) * PROD_W'(t_eff);
      prod_a <= PROD_W'(a_lvl) * PROD_W'(inv_t);
      sum    <= SUM_W'(prod_j) + SUM_W'(prod_a) + SUM_W'(ROUND);
      pix    <= en ? clamp_pix(sum[SUM_W-1:PIX_W]) : '0;
    end
  end
endmodule

// File: rtl/add_haze.sv
// Adds synthetic haze I = J*t + A*(1-t) to a video stream, parameters latched per frame.
// Optional depth fog (t falls with line number) is built with ADD_HAZE_DEPTH_FOG_EN.
module add_haze
  import haze_pkg::*;
(
  input  logic        pixelclk,
  input  logic        reset,
  input  logic [23:0] i_rgb,
  input  logic [7:0]  at,
  input  logic [7:0]  a,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de
);
  logic             vs_prev;
  logic             vs_rise;
  logic [PIX_W-1:0] t_frm;
  logic [PIX_W-1:0] a_frm;
  logic [PIX_W-1:0] t_use;
  logic [PIX_W-1:0] a_use;
  logic [PIX_W-1:0] t_eff;
  sync_t            sync_pipe [LATENCY];

  assign vs_rise = i_vsync & ~vs_prev;
  // New parameters apply to the pixel on the vsync edge itself, not one later.
  assign t_use = vs_rise ? at : t_frm;
  assign a_use = vs_rise ? a  : a_frm;

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      vs_prev <= 1'b0;
      t_frm   <= 8'd255;
      a_frm   <= 8'd0;
    end else begin
      vs_prev <= i_vsync;
      if (vs_rise) begin
        t_frm <= at;
        a_frm <= a;
      end
    end
  end

`ifdef ADD_HAZE_DEPTH_FOG_EN
  logic                  de_prev;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_CNT_W-1:0] line_use;
  logic [PIX_W-1:0]      line_dec;

  assign line_use = vs_rise ? '0 : line_cnt;
  assign line_dec = PIX_W'(line_use >> LINE_SHIFT);
  // Compare before subtracting so t_frm below the floor never wraps.
  assign t_eff = ({1'b0, t_use} >= ({1'b0, line_dec} + (PIX_W+1)'(T_MIN)))
                 ? (t_use - line_dec) : PIX_W'(T_MIN);

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      de_prev  <= 1'b0;
      line_cnt <= '0;
    end else begin
      de_prev <= i_de;
      if (vs_rise)
        line_cnt <= '0;
      else if (de_prev && !i_de && (line_cnt != '1))
        line_cnt <= line_cnt + 1'b1;
    end
  end
`else
  assign t_eff = t_use;
`endif

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= '{hsync: i_hsync, vsync: i_vsync, de: i_de};
      for (int i = 1; i < LATENCY; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign o_hsync = sync_pipe[LATENCY-1].hsync;
  assign o_vsync = sync_pipe[LATENCY-1].vsync;
  assign o_de    = sync_pipe[LATENCY-1].de;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    haze_blend_ch u_ch (
      .clk   (pixelclk),
      .rst   (reset),
      .j     (i_rgb[c*PIX_W +: PIX_W]),
      .t_eff (t_eff),
      .a_lvl (a_use),
      .en    (sync_pipe[LATENCY-2].de),
      .pix   (o_rgb[c*PIX_W +: PIX_W])
    );
  end
endmodule

// File: tb/tb_add_haze.sv
// Self-checking bench for add_haze: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model with a 3-deep expected queue.
module tb_add_haze;
  logic        pixelclk = 1'b0;
  logic        reset    = 1'b1;
  logic [23:0] i_rgb    = '0;
  logic [7:0]  at       = '0;
  logic [7:0]  a        = '0;
  logic        i_hsync  = 1'b0;
  logic        i_vsync  = 1'b0;
  logic        i_de     = 1'b0;
  logic [23:0] o_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;

  always #5 pixelclk = ~pixelclk;

  add_haze dut (
    .pixelclk (pixelclk),
    .reset    (reset),
    .i_rgb    (i_rgb),
    .at       (at),
    .a        (a),
    .i_hsync  (i_hsync),
    .i_vsync  (i_vsync),
    .i_de     (i_de),
    .o_rgb    (o_rgb),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [26:0] exp_q[$];
  logic [26:0] obs;
  logic [26:0] expv;
  logic        have;

  // Frame-level model state: parameters in force, lines seen, previous timing.
  int   m_t;
  int   m_a;
  int   m_line;
  logic m_vs_prev;
  logic m_de_prev;

  function automatic int haze_ref(int j, int t, int av);
    int v;
    v = (j * t + av * (256 - t) + 128) / 256;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int t_eff_ref(int t, int line);
`ifdef ADD_HAZE_DEPTH_FOG_EN
    int v;
    v = t - line / 4;
    return (v < 16) ? 16 : v;
`else
    return t + 0 * line;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    m_t = 255;
    m_a = 0;
    m_line = 0;
    m_vs_prev = 1'b0;
    m_de_prev = 1'b0;
  endtask

  // One pixel slot: sample the output due now, drive the next input, predict it.
  task automatic step(input logic [23:0] rgb, input logic [7:0] t, input logic [7:0] av,
                      input logic hs, input logic vs, input logic de);
    logic        rise;
    int          te;
    logic [23:0] e_rgb;
    @(negedge pixelclk);
    have = 1'b0;
    if (exp_q.size() >= 3) begin
      obs  = {o_rgb, o_hsync, o_vsync, o_de};
      expv = exp_q.pop_front();
      have = 1'b1;
    end
    i_rgb = rgb; at = t; a = av; i_hsync = hs; i_vsync = vs; i_de = de;
    rise = vs && !m_vs_prev;
    if (rise) begin
      m_t = int'(t);
      m_a = int'(av);
      m_line = 0;
    end
    te = t_eff_ref(m_t, m_line);
    e_rgb = '0;
    if (de) begin
      e_rgb[23:16] = 8'(haze_ref(int'(rgb[23:16]), te, m_a));
      e_rgb[15:8]  = 8'(haze_ref(int'(rgb[15:8]),  te, m_a));
      e_rgb[7:0]   = 8'(haze_ref(int'(rgb[7:0]),   te, m_a));
    end
    exp_q.push_back({e_rgb, hs, vs, de});
    if (!rise && m_de_prev && !de && m_line < 1023) m_line++;
    m_vs_prev = vs;
    m_de_prev = de;
  endtask

  task automatic test_reset();
    @(negedge pixelclk);
    n_cmp++;
    if (o_rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got=%h exp=000000", o_rgb); end
    n_cmp++;
    if (o_hsync !== 1'b0) begin n_bad++; $display("FAIL reset_hsync got=%b exp=0", o_hsync); end
    n_cmp++;
    if (o_vsync !== 1'b0) begin n_bad++; $display("FAIL reset_vsync got=%b exp=0", o_vsync); end
    n_cmp++;
    if (o_de !== 1'b0) begin n_bad++; $display("FAIL reset_de got=%b exp=0", o_de); end
    @(posedge pixelclk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       step(24'h0, 8'd128, 8'd100, 1'b0, 1'b0, 1'b0);
        1:       step(24'hC8C8C8, 8'd128, 8'd100, 1'b0, 1'b1, 1'b1);
        default: step(24'h0, 8'd128, 8'd100, 1'b0, 1'b1, 1'b0);
      endcase
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL basic i=%0d got=%h exp=%h", i, obs, expv); end
      end
    end
    n_cmp++;
    if (obs[26:3] !== 24'h969696 || obs[0] !== 1'b1)
      begin n_bad++; $display("FAIL basic_const got=%h de=%b exp=969696 de=1", obs[26:3], obs[0]); end
  endtask

  task automatic test_extremes();
    logic [23:0] j_v [2];
    logic [7:0]  t_v [2];
    logic [7:0]  a_v [2];
    logic [23:0] r_v [2];
    j_v[0] = 24'h00FF11; t_v[0] = 8'd0;   a_v[0] = 8'd255; r_v[0] = 24'hFFFFFF;
    j_v[1] = 24'hFFFFFF; t_v[1] = 8'd255; a_v[1] = 8'd0;   r_v[1] = 24'hFEFEFE;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 5; i++) begin
        case (i)
          0:       step(24'h0, t_v[s], a_v[s], 1'b0, 1'b0, 1'b0);
          1:       step(j_v[s], t_v[s], a_v[s], 1'b0, 1'b1, 1'b1);
          default: step(24'h0, 8'd77, 8'd33, 1'b0, 1'b1, 1'b0);
        endcase
        if (have) begin
          n_cmp++;
          if (obs !== expv) begin n_bad++; $display("FAIL extreme s=%0d i=%0d got=%h exp=%h", s, i, obs, expv); end
        end
      end
      n_cmp++;
      if (obs[26:3] !== r_v[s])
        begin n_bad++; $display("FAIL extreme_const s=%0d got=%h exp=%h", s, obs[26:3], r_v[s]); end
    end
  endtask

  task automatic test_param_hold();
    for (int i = 0; i < 15; i++) begin
      if (i == 0)       step(24'h0, 8'd128, 8'd100, 1'b0, 1'b0, 1'b0);
      else if (i == 1)  step(24'($urandom), 8'd128, 8'd100, 1'b0, 1'b1, 1'b1);
      else if (i < 6)   step(24'($urandom), 8'd64, 8'd100, 1'b0, 1'b1, 1'b1);
      else if (i == 6)  step(24'hC8C8C8, 8'd64, 8'd100, 1'b0, 1'b1, 1'b1);
      else if (i < 10)  step(24'h0, 8'd64, 8'd100, 1'b0, 1'b1, 1'b0);
      else if (i == 10) step(24'h0, 8'd64, 8'd100, 1'b0, 1'b0, 1'b0);
      else if (i == 11) step(24'hC8C8C8, 8'd64, 8'd100, 1'b0, 1'b1, 1'b1);
      else              step(24'h0, 8'd64, 8'd100, 1'b0, 1'b1, 1'b0);
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL hold i=%0d got=%h exp=%h", i, obs, expv); end
      end
      if (i == 9) begin
        n_cmp++;
        if (obs[26:3] !== 24'h969696) begin n_bad++; $display("FAIL hold_old got=%h exp=969696", obs[26:3]); end
      end
      if (i == 14) begin
        n_cmp++;
        if (obs[26:3] !== 24'h7D7D7D) begin n_bad++; $display("FAIL hold_new got=%h exp=7d7d7d", obs[26:3]); end
      end
    end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 40; i++) begin
      step(24'($urandom_range(1, 24'hFFFFFF)), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'b0);
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL blank i=%0d got=%h exp=%h", i, obs, expv); end
        if (i >= 3) begin
          n_cmp++;
          if (obs[26:3] !== 24'h0) begin n_bad++; $display("FAIL blank_zero i=%0d got=%h exp=000000", i, obs[26:3]); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic vs;
    vs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) vs = ~vs;
      step(24'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           vs, ($urandom_range(0, 3) != 0));
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, expv); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      step(24'($urandom), 8'd128, 8'd100, 1'b1, (i != 0), 1'b1);
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL rstmid_pre i=%0d got=%h exp=%h", i, obs, expv); end
      end
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_rgb, o_hsync, o_vsync, o_de} !== 27'h0)
      begin n_bad++; $display("FAIL rstmid_out got=%h exp=0000000", {o_rgb, o_hsync, o_vsync, o_de}); end
    @(posedge pixelclk);
    @(posedge pixelclk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(24'hC8C8C8, 8'd200, 8'd50, 1'b0, 1'b0, 1'b1);
      else        step(24'h0, 8'd200, 8'd50, 1'b0, 1'b0, 1'b0);
      if (have) begin
        n_cmp++;
        if (obs !== expv) begin n_bad++; $display("FAIL rstmid_post i=%0d got=%h exp=%h", i, obs, expv); end
      end
    end
    n_cmp++;
    if (obs[26:3] !== 24'hC7C7C7) begin n_bad++; $display("FAIL rstmid_dflt got=%h exp=c7c7c7", obs[26:3]); end
  endtask

`ifdef ADD_HAZE_DEPTH_FOG_EN
  task automatic test_depth_fog();
    int          lines [4];
    logic [23:0] res [4];
    lines[0] = 0; lines[1] = 40; lines[2] = 460; lines[3] = 0;
    res[0] = 24'h646464; res[1] = 24'h5C5C5C; res[2] = 24'h0D0D0D; res[3] = 24'h646464;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || k == 3) begin
        step(24'h0, 8'd128, 8'd0, 1'b0, 1'b0, 1'b0);
        if (have) begin
          n_cmp++;
          if (obs !== expv) begin n_bad++; $display("FAIL fog_vs k=%0d got=%h exp=%h", k, obs, expv); end
        end
      end
      for (int l = 0; l < lines[k]; l++) begin
        for (int p = 0; p < 2; p++) begin
          step(24'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, (p == 0));
          if (have) begin
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL fog_line k=%0d l=%0d got=%h exp=%h", k, l, obs, expv); end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (i == 0) step(24'hC8C8C8, 8'd128, 8'd0, 1'b0, 1'b1, 1'b1);
        else        step(24'h0, 8'd128, 8'd0, 1'b0, 1'b1, 1'b1);
        if (have) begin
          n_cmp++;
          if (obs !== expv) begin n_bad++; $display("FAIL fog_px k=%0d i=%0d got=%h exp=%h", k, i, obs, expv); end
        end
      end
      n_cmp++;
      if (obs[26:3] !== res[k]) begin n_bad++; $display("FAIL fog_const k=%0d got=%h exp=%h", k, obs[26:3], res[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_param_hold();
    test_blank();
    test_random();
    test_reset_mid();
`ifdef ADD_HAZE_DEPTH_FOG_EN
    test_depth_fog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
